// File: rtl/fdiv_seq.sv
// fdiv_seq: two-stage pipelined binary32 divider, flush-to-zero, truncated mantissa.
// Stage 1 captures operands; the divide is combinational into the stage-2 result register.
module fdiv_seq (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    input  logic [31:0] x1,
    input  logic [31:0] x2,
    output logic        out_valid,
    output logic [31:0] y
);
    logic        v1;
    logic [31:0] a, b;
    logic        s, lt;
    logic [7:0]  ea, eb;
    logic [23:0] ma, mb;
    logic [22:0] man;
    logic [9:0]  e;
    logic [31:0] zero, inf, y_next;
    always_ff @(posedge clk) begin
        if (rst) begin
            v1        <= 1'b0;
            out_valid <= 1'b0;
            y         <= '0;
        end else begin
            v1        <= in_valid;
            out_valid <= v1;
            if (v1) y <= y_next;
        end
        if (in_valid) begin
            a <= x1;
            b <= x2;
        end
    end
    always_comb begin
        s    = a[31] ^ b[31];
        ea   = a[30:23];
        eb   = b[30:23];
        ma   = {1'b1, a[22:0]};
        mb   = {1'b1, b[22:0]};
        zero = {s, 31'b0};
        inf  = {s, 8'hFF, 23'b0};
        // Pre-scaling the dividend when ma < mb lands the quotient in [1,2), so no post-shift is needed
        lt   = a[22:0] < b[22:0];
        man  = 23'((lt ? {ma, 24'b0} : {1'b0, ma, 23'b0}) / {24'b0, mb});
        e    = {2'b0, ea} - {2'b0, eb} + 10'd127 - {9'b0, lt};
        y_next = ea == 8'd0         ? zero :
                 eb == 8'd0         ? inf  :
                 ea == 8'hFF        ? inf  :
                 eb == 8'hFF        ? zero :
                 (e[9] || e == '0)  ? zero :
                 e >= 10'd255       ? inf  : {s, e[7:0], man};
    end
endmodule

// File: tb/tb_fdiv_seq.sv
// tb_fdiv_seq: directed and randomized checks of fdiv_seq against a real-arithmetic reference.
module tb_fdiv_seq;
    logic        clk = 0;
    logic        rst;
    logic        in_valid;
    logic [31:0] x1, x2;
    logic        out_valid;
    logic [31:0] y;
    int tests = 0;
    int fails = 0;

    fdiv_seq dut (.clk(clk), .rst(rst), .in_valid(in_valid), .x1(x1), .x2(x2),
                  .out_valid(out_valid), .y(y));

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp,
                         input int tol = 0);
        longint d;
        d = longint'(got) - longint'(exp);
        if (d < 0) d = -d;
        tests++;
        if (d > longint'(tol)) begin
            fails++;
            $display("FAIL %s: got %h expected %h (tol %0d)", tag, got, exp, tol);
        end
    endtask

    // Reference: classify specials, then divide the significands as reals and round to nearest.
    function automatic void model(input logic [31:0] a, input logic [31:0] b,
                                  output logic [31:0] r, output int tol);
        logic   s;
        int     ea, eb, ex;
        real    m, f;
        longint mt;
        s   = a[31] ^ b[31];
        ea  = int'(a[30:23]);
        eb  = int'(b[30:23]);
        tol = 0;
        if (ea == 0)        r = {s, 31'b0};
        else if (eb == 0)   r = {s, 8'hFF, 23'b0};
        else if (ea == 255) r = {s, 8'hFF, 23'b0};
        else if (eb == 255) r = {s, 31'b0};
        else begin
            m  = real'(int'({1'b1, a[22:0]})) / real'(int'({1'b1, b[22:0]}));
            ex = ea - eb + 127;
            if (m < 1.0) begin
                m  = m * 2.0;
                ex = ex - 1;
            end
            if (ex <= 0) r = {s, 31'b0};
            else if (ex >= 255) r = {s, 8'hFF, 23'b0};
            else begin
                f  = (m - 1.0) * 8388608.0;
                mt = longint'($rtoi(f + 0.5));
                if (mt >= 64'd8388608) begin
                    mt = 0;
                    ex = ex + 1;
                end
                r   = {s, 8'(ex), 23'(mt)};
                tol = 8;
            end
        end
    endfunction

    logic [31:0] sa[$], sb[$], se[$];
    int          st[$];

    task automatic push(input logic [31:0] a, input logic [31:0] b, input logic [31:0] e,
                        input int tol);
        sa.push_back(a); sb.push_back(b); se.push_back(e); st.push_back(tol);
    endtask

    // Drives queued ops back to back; each result is checked two negedges after its drive.
    task automatic run_stream(input string name);
        int n;
        n = sa.size();
        for (int c = 0; c < n + 2; c++) begin
            @(negedge clk);
            if (c >= 2) begin
                check($sformatf("%s[%0d].valid", name, c - 2), {31'b0, out_valid}, 32'd1);
                check($sformatf("%s[%0d] %h/%h", name, c - 2, sa[c-2], sb[c-2]), y, se[c-2], st[c-2]);
            end
            if (c < n) begin
                in_valid = 1'b1; x1 = sa[c]; x2 = sb[c];
            end else in_valid = 1'b0;
        end
        sa.delete(); sb.delete(); se.delete(); st.delete();
    endtask

    function automatic logic [22:0] pick_man();
        logic [22:0] tbl [7] = '{23'h0, 23'h1, 23'h2, 23'h380000, 23'h400000, 23'h5FFFFF, 23'h7FFFFF};
        return $urandom_range(1) == 0 ? tbl[$urandom_range(6)] : 23'($urandom);
    endfunction

    initial begin
        logic [31:0] a, b, e;
        int          tol;
        rst = 1'b1; in_valid = 1'b0; x1 = '0; x2 = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("reset.valid", {31'b0, out_valid}, 32'd0);
        check("reset.y", y, 32'd0);
        rst = 1'b0;

        // Latency: one op, visible exactly two edges later, then y holds.
        @(negedge clk);
        in_valid = 1'b1; x1 = 32'h40C00000; x2 = 32'h40000000;
        @(negedge clk);
        in_valid = 1'b0;
        check("lat.valid_early", {31'b0, out_valid}, 32'd0);
        @(negedge clk);
        check("lat.valid", {31'b0, out_valid}, 32'd1);
        check("lat.6div2", y, 32'h40400000);
        @(negedge clk);
        check("lat.valid_drop", {31'b0, out_valid}, 32'd0);
        check("lat.y_hold", y, 32'h40400000);

        // Directed values and special operands, streamed back to back.
        push(32'h40C00000, 32'h40000000, 32'h40400000, 0);
        push(32'h3F800000, 32'h40400000, 32'h3EAAAAAA, 1);
        push(32'hBF800000, 32'h40000000, 32'hBF000000, 0);
        push(32'h00400000, 32'h3F800000, 32'h00000000, 0);
        push(32'h00800000, 32'h40000000, 32'h00000000, 0);
        push(32'h7E800000, 32'h3E800000, 32'h7F800000, 0);
        push(32'h3F800000, 32'h80000000, 32'hFF800000, 0);
        push(32'h7F800000, 32'h3F800000, 32'h7F800000, 0);
        push(32'hBF800000, 32'h7F800000, 32'h80000000, 0);
        push(32'h80000000, 32'h00000000, 32'h80000000, 0);
        push(32'h7FC00000, 32'h3F800000, 32'h7F800000, 0);
        push(32'h3FFFFFFF, 32'h3F800001, 32'h3FFFFFFD, 1);
        run_stream("dir");

        // Reset while A,B,C are in flight: A and B emerge, C never does.
        @(negedge clk);
        in_valid = 1'b1; x1 = 32'h40C00000; x2 = 32'h40000000;
        @(negedge clk);
        x1 = 32'hBF800000; x2 = 32'h40000000;
        @(negedge clk);
        check("rst.A.valid", {31'b0, out_valid}, 32'd1);
        check("rst.A", y, 32'h40400000);
        x1 = 32'h3F800000; x2 = 32'h40400000;
        @(negedge clk);
        check("rst.B.valid", {31'b0, out_valid}, 32'd1);
        check("rst.B", y, 32'hBF000000);
        in_valid = 1'b0; rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("rst.valid", {31'b0, out_valid}, 32'd0);
        check("rst.y", y, 32'd0);
        @(negedge clk);
        check("rst.C_dropped", {31'b0, out_valid}, 32'd0);
        @(negedge clk);
        check("rst.idle", {31'b0, out_valid}, 32'd0);

        // Random sweep against the reference.
        for (int i = 0; i < 400; i++) begin
            a = {1'($urandom), 8'($urandom_range(253)), pick_man()};
            b = {1'($urandom), 8'($urandom_range(253, 1)), pick_man()};
            model(a, b, e, tol);
            push(a, b, e, tol);
        end
        run_stream("rnd");

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
